// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, flush, funct3, DataA, DataB, input busy, done, result);
  modport slave  (input start, flush, funct3, DataA, DataB, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply, 32-cycle restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

  state_t      state, nxt;
  logic        accept;
  logic [2:0]  op;
  logic        sa, sb, spec_q;
  logic [31:0] opd, spres;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        busy_q, done_q;
  logic [31:0] result_q;

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.result = result_q;

  // request decode
  logic        in_div, a_sgn, b_sgn, b_zero, ovf, special;
  logic [31:0] abs_a, abs_b, spval;
  always_comb begin
    in_div  = io.funct3[2];
    a_sgn   = io.DataA[31] & (io.funct3 != 3'b011) & (io.funct3 != 3'b101) & (io.funct3 != 3'b111);
    b_sgn   = io.DataB[31] & ((io.funct3 == 3'b000) | (io.funct3 == 3'b001) |
                              (io.funct3 == 3'b100) | (io.funct3 == 3'b110));
    abs_a   = a_sgn ? (32'd0 - io.DataA) : io.DataA;
    abs_b   = b_sgn ? (32'd0 - io.DataB) : io.DataB;
    b_zero  = (io.DataB == 32'd0);
    ovf     = ~io.funct3[0] & (io.DataA == 32'h8000_0000) & (io.DataB == 32'hFFFF_FFFF);
    special = in_div & (b_zero | ovf);
    if (b_zero)
      spval = io.funct3[1] ? io.DataA : 32'hFFFF_FFFF;
    else
      spval = io.funct3[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fprod, fprod_s;
  logic        fast;
  logic [31:0] spsel;
  always_comb begin
    fprod   = {32'd0, abs_a} * {32'd0, abs_b};
    fprod_s = (a_sgn ^ b_sgn) ? (64'd0 - fprod) : fprod;
    fast    = special | ~in_div;
    if (in_div)
      spsel = spval;
    else
      spsel = (io.funct3 == 3'b000) ? fprod_s[31:0] : fprod_s[63:32];
  end
`else
  logic        fast;
  logic [31:0] spsel;
  assign fast  = special;
  assign spsel = spval;
`endif

  // FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    case (state)
      IDLE:    if (io.start) begin
                 accept = 1'b1;
                 nxt    = fast ? FINISH : BUSY;
               end
      BUSY:    if (cnt == 5'd31) nxt = FINISH;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (io.flush) begin
      nxt    = IDLE;
      accept = 1'b0;
    end
  end

  // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, dividend/quotient}
  logic [32:0] msum, trial;
  logic [63:0] mstep, dstep;
  always_comb begin
    msum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    mstep = {msum, acc[31:1]};
    trial = {acc[63:32], acc[31]} - {1'b0, opd};
    dstep = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
  end

  logic [63:0] pm;
  logic [31:0] q, r, fin;
  always_comb begin
    pm = (sa ^ sb) ? (64'd0 - acc) : acc;
    q  = acc[31:0];
    r  = acc[63:32];
    if (!op[2])
      fin = (op == 3'b000) ? pm[31:0] : pm[63:32];
    else if (op[1])
      fin = sa ? (32'd0 - r) : r;
    else
      fin = (sa ^ sb) ? (32'd0 - q) : q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op       <= 3'd0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      spec_q   <= 1'b0;
      opd      <= 32'd0;
      spres    <= 32'd0;
      acc      <= 64'd0;
      cnt      <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (io.flush) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= 5'd0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op     <= io.funct3;
        sa     <= a_sgn;
        sb     <= b_sgn;
        opd    <= in_div ? abs_b : abs_a;
        acc    <= {32'd0, in_div ? abs_a : abs_b};
        cnt    <= 5'd0;
        spec_q <= fast;
        spres  <= spsel;
        busy_q <= ~fast;
      end else if (state == BUSY) begin
        acc <= op[2] ? dstep : mstep;
        cnt <= cnt + 5'd1;
      end else if (state == FINISH) begin
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
        result_q <= spec_q ? spres : fin;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops vs. arithmetic model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  muldiv_if io ();
  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      as, bs, ua, ub;
    logic [63:0] p;
    as = $signed(a);
    bs = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = as * bs; return p[31:0];  end
      3'd1: begin p = as * bs; return p[63:32]; end
      3'd2: begin p = as * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = as / bs; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = as % bs; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // edges from acceptance to done
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    io.start = 1'b1; io.funct3 = f; io.DataA = a; io.DataB = b;
    @(posedge clk); #1;
    io.start = 1'b0; io.funct3 = 3'($urandom); io.DataA = $urandom; io.DataB = $urandom;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
    int   lat, elat;
    logic b0;
    elat = exp_lat(f, a, b);
    issue(f, a, b);
    b0  = io.busy;
    lat = 0;
    while (io.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(elat));
    check({nm, " result"}, {32'd0, io.result}, {32'd0, exp});
    check({nm, " busy_start"}, {63'd0, b0}, {63'd0, elat > 1});
    check({nm, " busy_at_done"}, {63'd0, io.busy}, 64'd0);
  endtask

  vec_t        tbl[$];
  int          ndone, lat;
  logic [31:0] r0, a, b;
  logic [2:0]  f;

  initial begin
    io.start = 0; io.flush = 0; io.funct3 = 0; io.DataA = 0; io.DataB = 0;
    tbl = '{
      '{3'd0, 32'd7,          32'd6,          32'd42},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
      '{3'd5, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC},
      '{3'd5, 32'd1234,       32'd0,          32'hFFFF_FFFF},
      '{3'd4, 32'd1234,       32'd0,          32'hFFFF_FFFF},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
      '{3'd7, 32'hDEAD_BEEF,  32'd0,          32'hDEAD_BEEF},
      '{3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000},
      '{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF},
      '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0}
    };

    #12;
    check("reset busy", {63'd0, io.busy}, 64'd0);
    check("reset done", {63'd0, io.done}, 64'd0);
    check("reset result", {32'd0, io.result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    // flush in the middle of a divide
    r0 = io.result;
    issue(3'd4, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); io.flush = 1'b1;
    @(posedge clk); #1; io.flush = 1'b0;
    check("flush busy", {63'd0, io.busy}, 64'd0);
    check("flush result", {32'd0, io.result}, {32'd0, r0});
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (io.done) ndone++; end
    check("flush no done", 64'(ndone), 64'd0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "after flush");

    // flush and start together: request dropped
    @(negedge clk); io.start = 1'b1; io.flush = 1'b1; io.funct3 = 3'd5; io.DataA = 5; io.DataB = 0;
    @(posedge clk); #1; io.start = 1'b0; io.flush = 1'b0;
    ndone = 0;
    repeat (5) begin @(posedge clk); #1; if (io.done || io.busy) ndone++; end
    check("flush+start dropped", 64'(ndone), 64'd0);

    // start re-pulsed while busy
    issue(3'd5, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk); io.start = 1'b1; io.funct3 = 3'd0; io.DataA = 3; io.DataB = 3;
    @(posedge clk); #1; io.start = 1'b0;
    ndone = 0; lat = 0;
    for (int k = 6; k < 45; k++) begin
      @(posedge clk); #1;
      if (io.done) begin
        ndone++;
        if (ndone == 1) begin lat = k; r0 = io.result; end
      end
    end
    check("repulse done count", 64'(ndone), 64'd1);
    check("repulse latency", 64'(lat), 64'd33);
    check("repulse result", {32'd0, r0}, 64'd14);

    // asynchronous reset mid-operation
    issue(3'd0, 32'd9, 32'd9);
    repeat (19) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst busy", {63'd0, io.busy}, 64'd0);
    check("rst done", {63'd0, io.done}, 64'd0);
    check("rst result", {32'd0, io.result}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (io.done || io.busy) ndone++; end
    check("rst no done", 64'(ndone), 64'd0);

    // random ops against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: b = 32'(-$urandom_range(1, 20));
        4: a = 32'(-$urandom_range(0, 100));
        default: ;
      endcase
      run_op(f, a, b, model(f, a, b), $sformatf("rnd%0d f=%0d a=%h b=%h", i, f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle responder for the RV32M multiply/divide instructions. The datapath's execute stage issues a request with a one-cycle `start` pulse. The unit computes the result over multiple cycles and returns it with a one-cycle `done` pulse. It works alongside the single-cycle ALU: the ALU handles base-ISA operations, and this unit handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU while the pipeline stalls on `busy`.

## Interface
Parameters:
- none; datapath width is fixed at 32.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request strobe; sampled only in IDLE.
- `flush`  input  1  synchronous abort of any in-flight operation.
- `funct3`  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `DataA`  input  32  rs1 operand; multiplicand or dividend.
- `DataB`  input  32  rs2 operand; multiplier or divisor.
- `busy`  output  1  high from the cycle after `start` is accepted until the result is returned.
- `done`  output  1  one-cycle result-valid pulse.
- `result`  output  32  result register; holds its value until the next `done`.

## Operation
- **Reset.** While `rst_n` is low: `busy`=0, `done`=0, `result`=0, state=IDLE, and the iteration counter is 0.
- **States:**
  - IDLE: `start`=1 → BUSY, or → FINISH for a special case.
  - BUSY: counter reaches 31 → FINISH.
  - FINISH: drives `done`=1 → IDLE.
- **Accepting a request.** On `start` in IDLE:
  - Latch `funct3`, `DataA` and `DataB`.
  - For signed ops, record the operand signs, take absolute values, and work on the magnitudes.
- `start` is ignored in BUSY and FINISH. There is no queueing.
- **Multiply.** Shift-add, one multiplier bit per cycle, 64-bit accumulator, 32 iterations.
  - MUL returns the low word.
  - MULH, MULHSU and MULHU return the high word of the correctly signed 64-bit product.
  - MULHSU treats only `DataA` as signed.
  - The product is negated (two's complement over 64 bits) when the sign-adjusted operand signs differ.
- **Divide.** Restoring division, one quotient bit per cycle, 32 iterations.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- **Special cases.** These bypass iteration: IDLE → FINISH directly.
  - `DataB`=0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return `DataA`.
  - DIV with `DataA`=0x80000000 and `DataB`=0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- **Flush.**
  - `flush`=1 in any state → IDLE at the next edge, `busy`=0, `done` not asserted, `result` unchanged.
  - `flush` and `start` in the same IDLE cycle: flush wins and the request is dropped.

## Timing
- `start` accepted at edge N: `busy`=1 after edge N.
- Iterative path: 32 BUSY cycles, then `done`=1 after edge N+33.
  - `result` is valid in the same cycle as `done`.
  - `busy` drops together with the rise of `done`.
- Special-case path: `done`=1 after edge N+1; `busy` never asserts.
- A new `start` is accepted earliest in the cycle after `done`, which is back-to-back issue from IDLE.
- Asynchronous reset mid-operation: immediate abort, all outputs 0, no `done`.
- Operand inputs may change freely after the accepting edge; they are not re-sampled.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All four multiply ops use a single-cycle combinational 32×32 product, IDLE → FINISH, with `done` after edge N+1 and no `busy`.
  - Divide remains iterative.
- Not defined:
  - Multiply uses the 32-cycle shift-add path with `done` after edge N+33.
  - No multiplier operator is inferred.

## Test plan
- MUL, A=7, B=6 → `done` after edge N+33 (or N+1 with the macro) with `result`=42; MULHU, A=B=0xFFFFFFFF → `result`=0xFFFFFFFE.
- DIV, A=-7 (0xFFFFFFF9), B=2 → `result`=0xFFFFFFFD (-3); REM with the same operands → `result`=0xFFFFFFFF (-1); DIVU with the same operands → `result`=0x7FFFFFFC.
- DIVU, B=0 → `result`=0xFFFFFFFF after edge N+1 with `busy` never high; REM, A=0x80000000, B=0xFFFFFFFF → `result`=0 after edge N+1.
- DIV issued, `flush` pulsed at cycle N+10 → `busy`=0 after edge N+11, no `done`, `result` keeps its prior value; a new MULHSU, A=-1, B=2 issued next → `result`=0xFFFFFFFF.
- `start` re-pulsed at N+5 during BUSY → ignored, a single `done` at N+33; `rst_n` dropped at N+20 on a second op → `busy`, `done` and `result` become 0 at once, and there is no `done` after release.
